// File: rtl/video_pkg.sv
// Shared raster timing defaults and frame buffer geometry for the scan-out path.
package video_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int FB_ADDR_W = 19;
  localparam int FB_PIXELS = DEF_H_ACTIVE * DEF_V_ACTIVE;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  // Raw per-cycle raster flags; this is also the payload of the latency pipe.
  typedef struct packed {
    logic first;
    logic vs;
    logic hs;
    logic vis;
  } raster_flags_t;

endpackage

// File: rtl/frame_scanout_if.sv
// Frame buffer read port, renderer handshake and video output of the scan-out block.
interface frame_scanout_if;
  import video_pkg::*;

  logic     frame_done;
  logic     back_ready;
  fb_addr_t rd_addr;
  logic     rd_data;
  logic     swap;
  logic     hsync;
  logic     vsync;
  logic     de;
  logic     pixel;
  logic     frame_start;

  modport master (
    input  frame_done, rd_data,
    output back_ready, rd_addr, swap, hsync, vsync, de, pixel, frame_start
  );

  modport slave (
    output frame_done, rd_data,
    input  back_ready, rd_addr, swap, hsync, vsync, de, pixel, frame_start
  );

endinterface

// File: rtl/video_timing.sv
// Horizontal/vertical raster counters and the undelayed timing flags derived from them.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output raster_flags_t flags,
  output logic          swap_pt,
  output logic          frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_VIS  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FRONT);
  localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_VIS  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FRONT);
  localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  // Pixel counter wraps per line; line counter advances on each pixel wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Decode counter position into visibility, sync windows and frame markers.
  always_comb begin
    flags       = '0;
    flags.vis   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    flags.hs    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    flags.vs    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    flags.first = (h_cnt == '0) && (v_cnt == '0);
    swap_pt     = (h_cnt == '0) && (v_cnt == V_VIS);
    frame_end   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  end

endmodule

// File: rtl/frame_scanout.sv
// Display scan-out: raster timing, frame buffer addressing, read-latency alignment
// and the front/back buffer swap handshake with the renderer.
module frame_scanout
  import video_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FRONT     = DEF_H_FRONT,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BACK      = DEF_H_BACK,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FRONT     = DEF_V_FRONT,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BACK      = DEF_V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   RD_LATENCY  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  frame_scanout_if.master bus
);

  // Address saturates on the last visible pixel so it holds there through vblank.
  localparam fb_addr_t PIX_LAST = FB_ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  raster_flags_t                  raw;
  raster_flags_t [RD_LATENCY-1:0] pipe;
  raster_flags_t                  out_flags;
  logic                           swap_pt;
  logic                           frame_end;
  fb_addr_t                       rd_addr;
  logic                           pending;
  logic                           swap_fire;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .flags     (raw),
    .swap_pt   (swap_pt),
    .frame_end (frame_end)
  );

  // Swap only at the first blank line start; gating with rst drops a pending swap
  // during the reset cycle itself.
  assign swap_fire = rst & ce & pending & swap_pt;

  // Linear read address: advance after every visible cycle, restart with each frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_addr <= '0;
    end else if (ce) begin
      if (frame_end) begin
        rd_addr <= '0;
      end else if (raw.vis && (rd_addr != PIX_LAST)) begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  // Pending-swap flag: frame_done is captured even while stalled; a frame_done that
  // coincides with the swap re-arms the flag for the next frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= 1'b0;
    end else if (swap_fire) begin
      pending <= bus.frame_done;
    end else if (bus.frame_done) begin
      pending <= 1'b1;
    end
  end

  // Delay raw flags by the frame buffer read latency so they line up with rd_data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe <= '0;
    end else if (ce) begin
      pipe[0] <= raw;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign out_flags       = pipe[RD_LATENCY-1];
  assign bus.rd_addr     = rd_addr;
  assign bus.de          = out_flags.vis;
  assign bus.hsync       = out_flags.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign bus.vsync       = out_flags.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign bus.frame_start = out_flags.first & ce;
  assign bus.pixel       = bus.rd_data & out_flags.vis;
  assign bus.swap        = swap_fire;
  assign bus.back_ready  = ~pending;

endmodule

// File: doc/frame_scanout.md
Name: frame_scanout

Overview:
- Display-side scan controller directly downstream of the double-buffered 1-bpp frame buffer.
- Generates 640x480@60 raster timing and drives the frame buffer read address.
- Realigns the 1-cycle-latent read data with sync/blank, and owns the buffer `swap` strobe, issued only at vblank entry when the renderer has flagged a finished frame.
- Output feeds the video encoder (VGA/DVI serializer) in the pixel clock domain.

Parameters:
- H_ACTIVE 640: visible pixels per line
- H_FRONT 16: horizontal front porch, clocks
- H_SYNC 96: hsync width, clocks
- H_BACK 48: horizontal back porch, clocks
- V_ACTIVE 480: visible lines
- V_FRONT 10: vertical front porch, lines
- V_SYNC 2: vsync width, lines
- V_BACK 33: vertical back porch, lines
- SYNC_ACTIVE 1'b0: active level of hsync/vsync
- RD_LATENCY 1: frame buffer read latency, clocks (1..3)

Ports:
- clk  in  1  pixel clock (the frame buffer rd_clk)
- rst  in  1  synchronous, active-low reset
- ce  in  1  clock enable; low freezes all state
- frame_done  in  1  one-cycle pulse from renderer: back buffer complete
- back_ready  out  1  high when no swap is pending; renderer may draw into back buffer
- rd_addr  out  19  frame buffer read address
- rd_data  in  1  frame buffer read data, valid RD_LATENCY clocks after rd_addr
- swap  out  1  one-cycle strobe to toggle front/back buffers
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable, visible pixel
- pixel  out  1  pixel value, 0 outside visible area
- frame_start  out  1  one-cycle pulse aligned with first visible pixel of each frame

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-low. All state updates only on `posedge clk` with `ce`=1, except reset, which applies regardless of `ce`.
- Reset values:
  - h_cnt=0, v_cnt=0, rd_addr=0, pending=0, swap=0
  - hsync=vsync=~SYNC_ACTIVE, de=0, pixel=0, frame_start=0
  - back_ready=1
- Counters:
  - H_TOTAL=H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL=V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
  - h_cnt wraps H_TOTAL-1 -> 0. v_cnt increments on h wrap and wraps V_TOTAL-1 -> 0.
- Raw (undelayed) timing:
  - vis = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs active for H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vs active for lines V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC (490..491).
- Address generation:
  - rd_addr is a linear counter, not a multiply. It increments by 1 after each cycle with vis=1, so the address presented in a visible cycle equals v_cnt*640+h_cnt.
  - It resets to 0 when v_cnt wraps to 0. Maximum value is 307199, which fits in 19 bits.
  - rd_addr holds its value through blanking.
- Output alignment:
  - vis, hs, vs and the first-pixel flag pass through an RD_LATENCY-deep shift register.
  - de, hsync, vsync and frame_start are registered outputs aligned with rd_data.
  - pixel = rd_data & delayed vis.
  - Total latency from counter state to outputs = RD_LATENCY clocks.
- Swap handshake:
  - frame_done=1 sets pending. back_ready = ~pending.
  - swap is asserted for exactly one cycle when pending=1 at the cycle h_cnt==0 && v_cnt==V_ACTIVE. pending clears in that same cycle.
  - This point lies at least H_BLANK clocks after the last visible read, so no in-flight read straddles the swap.
  - frame_done while pending=1: ignored; pending stays 1 and exactly one swap occurs.
  - frame_done in the same cycle as swap: captured, so pending=1 afterwards (next swap one frame later).
  - No frame_done for a frame: no swap; the front buffer is re-displayed.
- ce=0:
  - Counters, pipeline and pending hold.
  - swap and frame_start are forced 0; a pending swap fires at the next qualifying enabled cycle.
  - frame_done pulses arriving while ce=0 are still captured.
- Reset mid-frame: return to reset values on the next clock. A pending swap is discarded. Scan restarts at (0,0).

Decomposition:
- Package `video_pkg`: H_/V_ timing defaults, derived H_TOTAL/V_TOTAL, FB_ADDR_W=19, FB_PIXELS=307200.
- Sub-module `video_timing`: h/v counters plus raw vis/hs/vs/first-pixel flags. frame_scanout adds address generation, latency alignment and the swap handshake.

Test Plan:
1. Reset: hold rst=0 for 3 clocks -> all outputs at reset values, back_ready=1. Release -> first de=1 at clock RD_LATENCY with rd_addr sequence 0,1,2…
2. Line and frame timing, ce=1 for a full frame:
   - hsync low exactly 96 clocks starting at line position 656+RD_LATENCY.
   - Line period 800.
   - vsync low on lines 490-491.
   - Frame period 420000 clocks.
   - 307200 de cycles; last rd_addr 307199; frame_start once per frame.
3. Data path: model the frame buffer with 1-cycle read returning rd_addr[0] -> pixel toggles 0,1,0,1 on every visible pixel, 0 whenever de=0.
4. Swap: pulse frame_done at line 100 -> back_ready drops next cycle. swap is a single pulse at h=0,v=480, and back_ready=1 the following cycle. A second frame_done at line 200 of the same frame produces no extra swap.
5. Simultaneous event: frame_done asserted exactly on the swap cycle -> swap pulses, back_ready stays 0, next swap occurs 420000 clocks later.
6. Stall and reset:
   - ce=0 for 50 clocks mid-line -> counters and outputs hold, swap=0, timing resumes seamlessly.
   - rst=0 at line 300 with pending=1 -> no swap issued, scan restarts at rd_addr=0, back_ready=1.
